// File: rtl/tag_search_ctrl.sv
// ----------------------------------------------------------------------------
// tag_search_ctrl
//   Sequential search over an 8-entry table of 3-bit tags. A single 3-bit
//   equality comparator is time-shared across the table, so one entry is
//   tested per cycle in ascending index order. The lowest matching index
//   wins.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   wr_en    in   write wr_data into entry wr_idx and mark it valid
//   wr_idx   in   write index
//   wr_data  in   tag to store
//   clr      in   clear all valid bits (tag data kept)
//   start    in   search request, accepted only while idle
//   key      in   search key, sampled on the accepting edge
//   busy     out  search in progress (scan or result cycle)
//   done     out  one-cycle pulse, result valid
//   hit      out  a valid entry matched (held until next result)
//   hit_idx  out  lowest matching index, 0 on a miss (held)
// ----------------------------------------------------------------------------

// 3-bit equality comparator shared by the search sequencer.
module comparator3 (
    input  logic [2:0] i_a,
    input  logic [2:0] i_b,
    output logic       o_eq
);
    assign o_eq = (i_a == i_b);
endmodule

module tag_search_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_idx,
    input  logic [2:0] wr_data,
    input  logic       clr,
    input  logic       start,
    input  logic [2:0] key,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output logic [2:0] hit_idx
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] r_state;
    logic [2:0] r_tag [8];
    logic [7:0] r_valid;
    logic [2:0] r_key;
    logic [2:0] r_idx;
    logic       r_hit;
    logic [2:0] r_hit_idx;
    logic       r_busy;
    logic       r_done;

    logic [1:0] w_state_n;
    logic [7:0] w_valid_n;
    logic [2:0] w_key_n;
    logic [2:0] w_idx_n;
    logic       w_hit_n;
    logic [2:0] w_hit_idx_n;
    logic [2:0] w_tag_sel;
    logic       w_eq;
    logic       w_match;

    // The comparison sees the pre-write table; writes land at the edge.
    assign w_tag_sel = r_tag[r_idx];

    comparator3 u_cmp (
        .i_a  (w_tag_sel),
        .i_b  (r_key),
        .o_eq (w_eq)
    );

    assign w_match = w_eq & r_valid[r_idx];

    // Clear first, then the write, so a same-cycle write survives the clear.
    always_comb begin
        w_valid_n = clr ? 8'h00 : r_valid;
        if (wr_en) begin
            w_valid_n[wr_idx] = 1'b1;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_key_n     = r_key;
        w_idx_n     = r_idx;
        w_hit_n     = r_hit;
        w_hit_idx_n = r_hit_idx;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_key_n   = key;
                    w_idx_n   = 3'd0;
                    w_state_n = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_match) begin
                    w_hit_n     = 1'b1;
                    w_hit_idx_n = r_idx;
                    w_state_n   = ST_DONE;
                end else if (r_idx == 3'd7) begin
                    w_hit_n     = 1'b0;
                    w_hit_idx_n = 3'd0;
                    w_state_n   = ST_DONE;
                end else begin
                    w_idx_n = r_idx + 3'd1;
                end
            end
            ST_DONE: begin
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_valid   <= 8'h00;
            r_key     <= 3'd0;
            r_idx     <= 3'd0;
            r_hit     <= 1'b0;
            r_hit_idx <= 3'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_valid   <= w_valid_n;
            r_key     <= w_key_n;
            r_idx     <= w_idx_n;
            r_hit     <= w_hit_n;
            r_hit_idx <= w_hit_idx_n;
            // Status flags registered from the next state so outputs are flops.
            r_busy    <= (w_state_n != ST_IDLE);
            r_done    <= (w_state_n == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_tag[i] <= 3'd0;
            end
        end else if (wr_en) begin
            r_tag[wr_idx] <= wr_data;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign hit     = r_hit;
    assign hit_idx = r_hit_idx;

endmodule

// File: tb/tb_tag_search_ctrl.sv
module tb_tag_search_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [2:0] wr_data;
    logic       clr;
    logic       start;
    logic [2:0] key;
    logic       busy;
    logic       done;
    logic       hit;
    logic [2:0] hit_idx;

    tag_search_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .clr     (clr),
        .start   (start),
        .key     (key),
        .busy    (busy),
        .done    (done),
        .hit     (hit),
        .hit_idx (hit_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
        logic [7:0] lat;
    } exp_t;

    exp_t sb[$];
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [2:0] idx, input logic [2:0] data);
        wr_en   = 1'b1;
        wr_idx  = idx;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    // Push expectation, present start for one cycle (through E0).
    task automatic start_search(input logic [2:0] k, input logic eh, input logic [2:0] ei,
                                input logic [7:0] el, output int base);
        exp_t e;
        e.hit = eh;
        e.idx = ei;
        e.lat = el;
        sb.push_back(e);
        base  = done_cnt;
        start = 1'b1;
        key   = k;
        tick();
        start = 1'b0;
    endtask

    // n0 = cycles elapsed since the start cycle when called.
    task automatic wait_result(input string tag, input int n0, input int base);
        int   n;
        exp_t e;
        n = n0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        chk({tag, " done_seen"}, {31'd0, done}, 32'd1);
        chk({tag, " latency"}, n, {24'd0, e.lat});
        chk({tag, " hit"}, {31'd0, hit}, {31'd0, e.hit});
        chk({tag, " hit_idx"}, {29'd0, hit_idx}, {29'd0, e.idx});
        chk({tag, " busy_in_done"}, {31'd0, busy}, 32'd1);
        tick();
        chk({tag, " busy_after"}, {31'd0, busy}, 32'd0);
        chk({tag, " done_after"}, {31'd0, done}, 32'd0);
        chk({tag, " hit_held"}, {31'd0, hit}, {31'd0, e.hit});
        chk({tag, " hit_idx_held"}, {29'd0, hit_idx}, {29'd0, e.idx});
        chk({tag, " done_pulses"}, done_cnt - base, 32'd1);
    endtask

    initial begin
        int base;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_idx  = 3'd0;
        wr_data = 3'd0;
        clr     = 1'b0;
        start   = 1'b0;
        key     = 3'd0;
        tick();
        tick();
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset hit", {31'd0, hit}, 32'd0);
        chk("reset hit_idx", {29'd0, hit_idx}, 32'd0);
        rst = 1'b0;
        tick();

        // Table 5,3,5,0 in entries 0..3.
        write(3'd0, 3'd5);
        write(3'd1, 3'd3);
        write(3'd2, 3'd5);
        write(3'd3, 3'd0);

        start_search(3'd5, 1'b1, 3'd0, 8'd2, base);
        wait_result("key5", 1, base);
        start_search(3'd0, 1'b1, 3'd3, 8'd5, base);
        wait_result("key0", 1, base);
        start_search(3'd7, 1'b0, 3'd0, 8'd9, base);
        wait_result("key7", 1, base);

        // All tags 0, all invalid after clr.
        for (int i = 0; i < 4; i++) write(i[2:0], 3'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        start_search(3'd0, 1'b0, 3'd0, 8'd9, base);
        wait_result("clr_miss", 1, base);

        // Entry 1 = 1 would win if the ignored key=1 start were taken.
        write(3'd1, 3'd1);
        start_search(3'd0, 1'b1, 3'd6, 8'd8, base);
        tick();
        tick();
        // Now idx=2: write entry 6 ahead of the scan, and try a second start.
        chk("scan busy", {31'd0, busy}, 32'd1);
        wr_en   = 1'b1;
        wr_idx  = 3'd6;
        wr_data = 3'd0;
        start   = 1'b1;
        key     = 3'd1;
        tick();
        wr_en   = 1'b0;
        tick();
        start   = 1'b0;
        wait_result("midscan_wr", 5, base);
        repeat (12) tick();
        chk("ignored start pulses", done_cnt - base, 32'd1);
        chk("ignored start hit_idx", {29'd0, hit_idx}, 32'd6);

        // Reset while scanning at idx=4.
        start = 1'b1;
        key   = 3'd0;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre_rst busy", {31'd0, busy}, 32'd1);
        base = done_cnt;
        rst  = 1'b1;
        #1;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst hit", {31'd0, hit}, 32'd0);
        chk("rst hit_idx", {29'd0, hit_idx}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("rst no done", done_cnt - base, 32'd0);
        start_search(3'd0, 1'b0, 3'd0, 8'd9, base);
        wait_result("post_rst miss", 1, base);

        // Same-cycle clr + write: only entry 2 stays valid.
        write(3'd0, 3'd4);
        write(3'd1, 3'd4);
        clr     = 1'b1;
        wr_en   = 1'b1;
        wr_idx  = 3'd2;
        wr_data = 3'd4;
        tick();
        clr     = 1'b0;
        wr_en   = 1'b0;
        start_search(3'd4, 1'b1, 3'd2, 8'd4, base);
        wait_result("clr_wr key4", 1, base);
        start_search(3'd0, 1'b0, 3'd0, 8'd9, base);
        wait_result("clr_wr key0", 1, base);

        chk("scoreboard empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
